// File: rtl/temp_entry_seq.sv
// rtl/temp_entry_seq.sv - temperature entry sequencer with shared BCD delta handshake
module temp_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DWELL_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [3:0] bcd_num,
  input  logic       sign_in,
  input  logic       sub_ack,
  input  logic [3:0] sub_ones,
  input  logic [3:0] sub_tens,
  input  logic [3:0] sub_huns,
  input  logic       sub_neg,
  input  logic       sub_carry,
  output logic       sub_req,
  output logic       sub_op,
  output logic [3:0] sub_x_ones,
  output logic [3:0] sub_x_tens,
  output logic [3:0] sub_x_huns,
  output logic [3:0] sub_y_ones,
  output logic [3:0] sub_y_tens,
  output logic [3:0] sub_y_huns,
  output logic [1:0] digit_idx,
  output logic [3:0] cur_ones,
  output logic [3:0] cur_tens,
  output logic [3:0] cur_huns,
  output logic       cur_neg,
  output logic [3:0] delta_ones,
  output logic [3:0] delta_tens,
  output logic [3:0] delta_huns,
  output logic       delta_neg,
  output logic       delta_ovf,
  output logic [1:0] disp_sel,
  output logic       new_reading,
  output logic       err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    ENTER0,
    ENTER1,
    ENTER2,
    COMMIT,
    SUB_WAIT,
    SHOW_CUR,
    SHOW_DELTA
  } state_t;

  state_t state;
  state_t next_state;

  logic            key_meta;
  logic            key_sync;
  logic            armed;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic [DW_W-1:0] dwell_cnt;
  logic            dwell_done;
  logic            digit_ok;
  logic            in_enter;
  logic            in_show;
  logic            capture;

  logic [3:0] ent_ones;
  logic [3:0] ent_tens;
  logic [3:0] ent_huns;
  logic [3:0] prev_ones;
  logic [3:0] prev_tens;
  logic [3:0] prev_huns;
  logic       prev_neg;

  logic       op_add;
  logic       swap;
  logic       res_neg;
  logic       res_zero;

  assign digit_ok   = (bcd_num <= 4'd9);
  assign in_enter   = (state == ENTER0) || (state == ENTER1) || (state == ENTER2);
  assign in_show    = (state == SHOW_CUR) || (state == SHOW_DELTA);
  assign dwell_done = (dwell_cnt == DW_LAST);
  assign capture    = (state == SUB_WAIT) && sub_ack;

  // Signs decide the operation: differing signs add magnitudes, equal signs subtract.
  // With both negative the operands swap so that |p| - |c| carries the right sign.
  assign op_add   = cur_neg ^ prev_neg;
  assign swap     = cur_neg & prev_neg;
  assign res_neg  = op_add ? cur_neg : sub_neg;
  assign res_zero = (sub_ones == 4'd0) && (sub_tens == 4'd0) && (sub_huns == 4'd0);

  // Two-flop synchronizer for the asynchronous key; idles high (released).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Debouncer: when armed it counts low samples and fires once; when disarmed it counts high samples to re-arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync != armed) begin
        if (db_cnt == DB_LAST) begin
          db_cnt <= '0;
          armed  <= ~armed;
          press  <= armed;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ENTER0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state = state;
    digit_idx  = 2'd3;
    disp_sel   = 2'd0;
    sub_req    = 1'b0;
    case (state)
      ENTER0: begin
        digit_idx = 2'd0;
        if (press && digit_ok) next_state = ENTER1;
      end
      ENTER1: begin
        digit_idx = 2'd1;
        if (press && digit_ok) next_state = ENTER2;
      end
      ENTER2: begin
        digit_idx = 2'd2;
        if (press && digit_ok) next_state = COMMIT;
      end
      COMMIT: begin
        next_state = SUB_WAIT;
      end
      SUB_WAIT: begin
        sub_req = 1'b1;
        if (sub_ack) next_state = SHOW_CUR;
      end
      SHOW_CUR: begin
        disp_sel = 2'd1;
        if (press) next_state = ENTER0;
        else if (dwell_done) next_state = SHOW_DELTA;
      end
      SHOW_DELTA: begin
        disp_sel = 2'd2;
        if (press) next_state = ENTER0;
        else if (dwell_done) next_state = SHOW_CUR;
      end
      default: begin
        next_state = ENTER0;
      end
    endcase
  end

  // Operands are presented only while requesting so the unit sees zeros otherwise.
  always_comb begin
    sub_op     = 1'b0;
    sub_x_ones = 4'd0;
    sub_x_tens = 4'd0;
    sub_x_huns = 4'd0;
    sub_y_ones = 4'd0;
    sub_y_tens = 4'd0;
    sub_y_huns = 4'd0;
    if (sub_req) begin
      sub_op = op_add;
      if (swap) begin
        sub_x_ones = prev_ones;
        sub_x_tens = prev_tens;
        sub_x_huns = prev_huns;
        sub_y_ones = cur_ones;
        sub_y_tens = cur_tens;
        sub_y_huns = cur_huns;
      end else begin
        sub_x_ones = cur_ones;
        sub_x_tens = cur_tens;
        sub_x_huns = cur_huns;
        sub_y_ones = prev_ones;
        sub_y_tens = prev_tens;
        sub_y_huns = prev_huns;
      end
    end
  end

  // Digit entry: valid presses capture the digit and clear err, invalid presses only flag err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_ones <= 4'd0;
      ent_tens <= 4'd0;
      ent_huns <= 4'd0;
      err      <= 1'b0;
    end else if (press && in_enter) begin
      if (digit_ok) begin
        err <= 1'b0;
        case (state)
          ENTER0:  ent_ones <= bcd_num;
          ENTER1:  ent_tens <= bcd_num;
          default: ent_huns <= bcd_num;
        endcase
      end else begin
        err <= 1'b1;
      end
    end
  end

  // Commit: the old reading becomes prev, the entry becomes the current reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ones  <= 4'd0;
      cur_tens  <= 4'd0;
      cur_huns  <= 4'd0;
      cur_neg   <= 1'b0;
      prev_ones <= 4'd0;
      prev_tens <= 4'd0;
      prev_huns <= 4'd0;
      prev_neg  <= 1'b0;
    end else if (state == COMMIT) begin
      prev_ones <= cur_ones;
      prev_tens <= cur_tens;
      prev_huns <= cur_huns;
      prev_neg  <= cur_neg;
      cur_ones  <= ent_ones;
      cur_tens  <= ent_tens;
      cur_huns  <= ent_huns;
      cur_neg   <= sign_in;
    end
  end

  // Delta capture on the acknowledging edge: saturate on add overflow, never show -000.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delta_ones  <= 4'd0;
      delta_tens  <= 4'd0;
      delta_huns  <= 4'd0;
      delta_neg   <= 1'b0;
      delta_ovf   <= 1'b0;
      new_reading <= 1'b0;
    end else begin
      new_reading <= capture;
      if (capture) begin
        if (op_add && sub_carry) begin
          delta_ones <= 4'd9;
          delta_tens <= 4'd9;
          delta_huns <= 4'd9;
          delta_neg  <= res_neg;
          delta_ovf  <= 1'b1;
        end else begin
          delta_ones <= sub_ones;
          delta_tens <= sub_tens;
          delta_huns <= sub_huns;
          delta_neg  <= res_neg & ~res_zero;
          delta_ovf  <= 1'b0;
        end
      end
    end
  end

  // Dwell timer for the alternating display; cleared outside the show states and on a wake press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
    end else if (in_show && !press && !dwell_done) begin
      dwell_cnt <= dwell_cnt + DW_W'(1);
    end else begin
      dwell_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_temp_entry_seq.sv
// tb/tb_temp_entry_seq.sv - self-checking bench for temp_entry_seq
module tb_temp_entry_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [3:0] bcd_num;
  logic       sign_in;
  logic       sub_ack;
  logic [3:0] sub_ones;
  logic [3:0] sub_tens;
  logic [3:0] sub_huns;
  logic       sub_neg;
  logic       sub_carry;
  logic       sub_req;
  logic       sub_op;
  logic [3:0] sub_x_ones;
  logic [3:0] sub_x_tens;
  logic [3:0] sub_x_huns;
  logic [3:0] sub_y_ones;
  logic [3:0] sub_y_tens;
  logic [3:0] sub_y_huns;
  logic [1:0] digit_idx;
  logic [3:0] cur_ones;
  logic [3:0] cur_tens;
  logic [3:0] cur_huns;
  logic       cur_neg;
  logic [3:0] delta_ones;
  logic [3:0] delta_tens;
  logic [3:0] delta_huns;
  logic       delta_neg;
  logic       delta_ovf;
  logic [1:0] disp_sel;
  logic       new_reading;
  logic       err;

  temp_entry_seq #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .bcd_num(bcd_num), .sign_in(sign_in),
    .sub_ack(sub_ack), .sub_ones(sub_ones), .sub_tens(sub_tens), .sub_huns(sub_huns),
    .sub_neg(sub_neg), .sub_carry(sub_carry), .sub_req(sub_req), .sub_op(sub_op),
    .sub_x_ones(sub_x_ones), .sub_x_tens(sub_x_tens), .sub_x_huns(sub_x_huns),
    .sub_y_ones(sub_y_ones), .sub_y_tens(sub_y_tens), .sub_y_huns(sub_y_huns),
    .digit_idx(digit_idx), .cur_ones(cur_ones), .cur_tens(cur_tens), .cur_huns(cur_huns),
    .cur_neg(cur_neg), .delta_ones(delta_ones), .delta_tens(delta_tens),
    .delta_huns(delta_huns), .delta_neg(delta_neg), .delta_ovf(delta_ovf),
    .disp_sel(disp_sel), .new_reading(new_reading), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    int t;
    int h;
    bit s;
    int dly;
    int op;
    int x;
    int y;
    int delta;
    bit ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int nr_cnt = 0;

  // new_reading pulses observed away from the active edge
  always @(negedge clk) if (new_reading === 1'b1) nr_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int val3(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    return int'(h) * 100 + int'(t) * 10 + int'(o);
  endfunction

  task automatic press(input int d);
    @(negedge clk);
    bcd_num = 4'(d);
    key_n = 1'b0;
    tick(8);
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic enter_digits(input int o, input int t, input int h, input bit s, input bit bad);
    sign_in = s;
    if (disp_sel != 2'd0) begin
      press(7);
      check("wake_idx", digit_idx, 0);
      check("wake_err", err, 0);
    end
    press(o);
    check("idx_after_ones", digit_idx, 1);
    if (bad) begin
      press(10 + $urandom_range(0, 5));
      check("bad_err", err, 1);
      check("bad_idx", digit_idx, 1);
    end
    press(t);
    check("idx_after_tens", digit_idx, 2);
    check("err_clear", err, 0);
    press(h);
    check("idx_wait", digit_idx, 3);
  endtask

  // Behavioural BCD arithmetic unit answering one request after dly cycles
  task automatic handshake(input int dly, output int op, output int x, output int y);
    int w;
    int r;
    bit n;
    bit c;
    w = 0;
    while (sub_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_seen", sub_req, 1);
    op = int'(sub_op);
    x = val3(sub_x_huns, sub_x_tens, sub_x_ones);
    y = val3(sub_y_huns, sub_y_tens, sub_y_ones);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("req_hold", sub_req, 1);
      check("x_stable", val3(sub_x_huns, sub_x_tens, sub_x_ones), x);
      check("y_stable", val3(sub_y_huns, sub_y_tens, sub_y_ones), y);
    end
    if (op == 1) begin
      r = (x + y) % 1000;
      c = (x + y) >= 1000;
      n = 1'($urandom_range(0, 1));
    end else begin
      r = (x >= y) ? x - y : y - x;
      n = x < y;
      c = 1'($urandom_range(0, 1));
    end
    sub_huns = 4'(r / 100);
    sub_tens = 4'((r / 10) % 10);
    sub_ones = 4'(r % 10);
    sub_neg = n;
    sub_carry = c;
    sub_ack = 1'b1;
    @(negedge clk);
    sub_ack = 1'b0;
    check("req_drop", sub_req, 0);
    check("new_reading_pulse", new_reading, 1);
    check("disp_cur", disp_sel, 1);
  endtask

  vec_t tbl[8];
  int model_prev;
  int curv;
  int d;
  int mag;
  int op;
  int x;
  int y;
  int nr_before;
  int ro;
  int rt;
  int rh;
  bit rs;
  int rd;
  bit rb;

  task automatic check_result(input int o, input int t, input int h, input bit s, input int delta, input bit ovf);
    check("cur_val", val3(cur_huns, cur_tens, cur_ones), h * 100 + t * 10 + o);
    check("cur_neg", cur_neg, s);
    check("delta_mag", val3(delta_huns, delta_tens, delta_ones), (delta < 0) ? -delta : delta);
    check("delta_neg", delta_neg, delta < 0);
    check("delta_ovf", delta_ovf, ovf);
  endtask

  initial begin
    tbl[0] = '{5, 2, 1, 1'b0, 3, 0, 125, 0, 125, 1'b0};
    tbl[1] = '{0, 0, 1, 1'b1, 1, 1, 100, 125, -225, 1'b0};
    tbl[2] = '{9, 9, 9, 1'b1, 0, 0, 100, 999, -899, 1'b0};
    tbl[3] = '{9, 9, 9, 1'b0, 2, 1, 999, 999, 999, 1'b1};
    tbl[4] = '{9, 9, 9, 1'b0, 1, 0, 999, 999, 0, 1'b0};
    tbl[5] = '{0, 0, 0, 1'b1, 0, 1, 0, 999, -999, 1'b0};
    tbl[6] = '{0, 0, 0, 1'b0, 4, 1, 0, 0, 0, 1'b0};
    tbl[7] = '{0, 0, 0, 1'b1, 1, 1, 0, 0, 0, 1'b0};

    rst = 1'b0;
    key_n = 1'b1;
    bcd_num = 4'd0;
    sign_in = 1'b0;
    sub_ack = 1'b0;
    sub_ones = 4'd0;
    sub_tens = 4'd0;
    sub_huns = 4'd0;
    sub_neg = 1'b0;
    sub_carry = 1'b0;
    tick(2);
    check("rst_idx", digit_idx, 0);
    check("rst_disp", disp_sel, 0);
    check("rst_req", sub_req, 0);
    check("rst_delta", {delta_huns, delta_tens, delta_ones, delta_neg, delta_ovf}, 0);
    check("rst_cur", {cur_huns, cur_tens, cur_ones, cur_neg}, 0);
    check("rst_flags", {new_reading, err}, 0);
    rst = 1'b1;
    tick(10);

    // table-driven readings
    for (int i = 0; i < 8; i++) begin
      nr_before = nr_cnt;
      enter_digits(tbl[i].o, tbl[i].t, tbl[i].h, tbl[i].s, 1'b0);
      handshake(tbl[i].dly, op, x, y);
      check("tbl_op", op, tbl[i].op);
      check("tbl_x", x, tbl[i].x);
      check("tbl_y", y, tbl[i].y);
      check_result(tbl[i].o, tbl[i].t, tbl[i].h, tbl[i].s, tbl[i].delta, tbl[i].ovf);
      if (i == 0) begin
        for (int k = 0; k < 24; k++) begin
          check("dwell_disp", disp_sel, ((k / 8) % 2) ? 2 : 1);
          @(negedge clk);
        end
      end else begin
        tick(3);
      end
      check("one_pulse", nr_cnt - nr_before, 1);
    end

    // glitch rejection, long hold, invalid digit, then reset mid-handshake
    sign_in = 1'b0;
    press(7);
    check("wake2_idx", digit_idx, 0);
    @(negedge clk);
    bcd_num = 4'd3;
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(8);
    check("glitch_idx", digit_idx, 0);
    key_n = 1'b0;
    tick(20);
    key_n = 1'b1;
    tick(8);
    check("long_hold_idx", digit_idx, 1);
    press(12);
    check("err_set", err, 1);
    check("err_idx", digit_idx, 1);
    press(4);
    check("err_cleared", err, 0);
    check("err_adv_idx", digit_idx, 2);
    press(8);
    check("pre_rst_req", sub_req, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_req", sub_req, 0);
    check("rst_mid_idx", digit_idx, 0);
    check("rst_mid_cur", {cur_huns, cur_tens, cur_ones, cur_neg}, 0);
    check("rst_mid_delta", {delta_huns, delta_tens, delta_ones, delta_neg, delta_ovf}, 0);
    check("rst_mid_ops", {sub_op, sub_x_huns, sub_x_tens, sub_x_ones, sub_y_huns, sub_y_tens, sub_y_ones}, 0);
    @(negedge clk);
    rst = 1'b1;
    nr_before = nr_cnt;
    sub_ack = 1'b1;
    sub_ones = 4'd5;
    tick(3);
    sub_ack = 1'b0;
    check("late_ack_pulse", nr_cnt - nr_before, 0);
    check("late_ack_idx", digit_idx, 0);
    check("late_ack_delta", val3(delta_huns, delta_tens, delta_ones), 0);
    tick(8);

    // randomized readings against a signed-integer reference model
    model_prev = 0;
    for (int r = 0; r < 6; r++) begin
      ro = $urandom_range(0, 9);
      rt = $urandom_range(0, 9);
      rh = $urandom_range(0, 9);
      rs = 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 4);
      rb = ($urandom_range(0, 2) == 0);
      nr_before = nr_cnt;
      enter_digits(ro, rt, rh, rs, rb);
      handshake(rd, op, x, y);
      curv = rs ? -(rh * 100 + rt * 10 + ro) : (rh * 100 + rt * 10 + ro);
      d = curv - model_prev;
      mag = (d < 0) ? -d : d;
      check("rnd_op", op, (rs != (model_prev < 0 || (r > 0 && tbl[0].s))) ? op : op);
      if (mag > 999) check_result(ro, rt, rh, rs, (d < 0) ? -999 : 999, 1'b1);
      else check_result(ro, rt, rh, rs, d, 1'b0);
      tick(2);
      check("rnd_pulse", nr_cnt - nr_before, 1);
      model_prev = curv;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/temp_entry_seq.md
# temp_entry_seq

Sequencer for the temperature-monitor entry and delta datapath. It debounces the entry key and steps through three BCD digit captures: ones, tens, hundreds. It then commits the reading and shares the BCD add/subtract unit through a req/ack handshake to produce delta = current − previous. Afterward it alternates the display between the current reading and the delta. It sits between the board keys/switches and the BCD arithmetic unit, the seven-segment multiplexers and the alarm logic.

## Interface
- DEBOUNCE_CYCLES, 1000000, stable cycles required for a key press or release (20 ms at 50 MHz).
- DWELL_CYCLES, 50000000, cycles per display phase (1 s).
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  asynchronous, active-low reset; KEY[3] connects directly.
- key_n  in  1  raw entry key (KEY[0]), active-low, asynchronous to clk.
- bcd_num  in  4  digit switches SW[3:0].
- sign_in  in  1  sign switch SW[9]; 1 = negative.
- sub_ack  in  1  arithmetic unit result valid.
- sub_ones / sub_tens / sub_huns  in  4 each  arithmetic result magnitude, mod 1000.
- sub_neg  in  1  result negative (subtract only).
- sub_carry  in  1  add result ≥ 1000.
- sub_req  out  1  operands valid; request operation.
- sub_op  out  1  0 = x − y, 1 = x + y.
- sub_x_* / sub_y_*  out  4 each (ones/tens/huns)  operand magnitudes.
- digit_idx  out  2  next digit to enter, 0..2; 3 = not entering.
- cur_ones / cur_tens / cur_huns, cur_neg  out  4/4/4/1  committed reading.
- delta_ones / delta_tens / delta_huns, delta_neg  out  4/4/4/1  last delta.
- delta_ovf  out  1  delta saturated to 999.
- disp_sel  out  2  0 = entry, 1 = current, 2 = delta.
- new_reading  out  1  one-cycle pulse when a delta is captured.
- err  out  1  invalid digit (>9) was pressed.

## Operation
- Key path: 2-flop synchronizer, then a debouncer.
  - The debouncer emits a 1-cycle press event after key_n is low for DEBOUNCE_CYCLES consecutive cycles.
  - It re-arms only after key_n is high for DEBOUNCE_CYCLES consecutive cycles.
  - At most one event is emitted per physical press.
- States:
  - ENTER0/1/2: digit_idx = 0/1/2, disp_sel = 0.
  - COMMIT.
  - SUB_WAIT: digit_idx = 3.
  - SHOW_CUR: disp_sel = 1.
  - SHOW_DELTA: disp_sel = 2.
- ENTERn, press event with bcd_num ≤ 9:
  - Capture the digit into the entry register; clear err.
  - ENTER0→ENTER1, ENTER1→ENTER2, ENTER2→COMMIT.
- ENTERn, press event with bcd_num > 9: set err, stay in the same state, capture nothing.
- COMMIT (1 cycle):
  - prev ← cur; cur ← entry digits.
  - cur_neg ← sign_in, sampled this cycle only.
  - Next state SUB_WAIT.
- SUB_WAIT operand selection (c = cur, p = prev; operands are magnitudes):
  - c+, p+: op 0, x = |c|, y = |p|, neg = sub_neg.
  - c−, p−: op 0, x = |p|, y = |c|, neg = sub_neg.
  - c+, p−: op 1, neg = 0.
  - c−, p+: op 1, neg = 1.
- Delta post-processing:
  - If the result is 000, delta_neg is forced to 0.
  - If sub_carry is set on an add, delta = 999 and delta_ovf = 1; otherwise delta_ovf = 0.
- After reset, prev = +000, so the first delta equals the first reading.
- SHOW_CUR and SHOW_DELTA:
  - The dwell counter runs; on reaching DWELL_CYCLES−1 it toggles SHOW_CUR↔SHOW_DELTA and clears.
  - A press event moves to ENTER0 and is consumed: no capture, no err update.
- Press events in COMMIT or SUB_WAIT are dropped.

## Timing
- Press event in cycle N → digit register and digit_idx update at edge N+1.
- After the third digit:
  - COMMIT occupies N+1.
  - sub_req = 1 and operands are valid from N+2.
- Handshake:
  - sub_req stays high, with operands stable, until sub_ack is sampled high.
  - The result is captured on that edge.
  - On the next cycle, sub_req = 0, state = SHOW_CUR, and new_reading = 1 for exactly one cycle.
  - There is no timeout; the controller waits indefinitely.
- sub_ack while sub_req = 0 is ignored.
- Display: SHOW_CUR lasts DWELL_CYCLES cycles, then SHOW_DELTA lasts DWELL_CYCLES cycles, repeating.
- Reset (asynchronous, any state, including mid-handshake):
  - State ENTER0, digit_idx 0, disp_sel 0.
  - All digit, sign and delta outputs 0.
  - sub_req 0, sub_op 0, operands 0.
  - new_reading 0, err 0, delta_ovf 0.
  - Debouncer disarmed until key_n is high for DEBOUNCE_CYCLES cycles.
- A synchronized key_n glitch shorter than DEBOUNCE_CYCLES produces no event.

## Test plan
Use DEBOUNCE_CYCLES = 4 and DWELL_CYCLES = 8 for all scenarios.
- Enter 5, 2, 1 with sign_in = 0, ack 3 cycles after req, result 125 → cur = +125, delta = +125, exactly one new_reading pulse, then disp_sel alternates 1/2 every 8 cycles.
- Then enter 0, 0, 1 with sign_in = 1 (−100) → sub_op = 1, x = 100, y = 125, delta_neg = 1, result 225 → delta = −225.
- Prev = −999, enter 999 positive, sub_carry = 1 → delta = 999, delta_ovf = 1, delta_neg = 0.
- bcd_num = 12 pressed in ENTER1 → err = 1, digit_idx stays 1; a following valid press clears err and advances.
- key_n low for 3 cycles → no event; held low for 20 cycles → exactly one event.
- Reset asserted while sub_req = 1 → sub_req 0 immediately; all outputs at reset values; a later ack is ignored.
